// File: rtl/tagmem_flush_pkg.sv
// Shared types and geometry for the tag-memory flush/invalidate sequencer.
// TAGMEM_FLUSH_WRITEBACK_EN (see tagmem_flush_ctrl) selects dirty-line writeback.
package tagmem_flush_pkg;

   localparam int unsigned ABUS     = 64;
   localparam int unsigned WAYBITS  = 2;
   localparam int unsigned IBITS    = 6;
   localparam int unsigned LNBITS   = 5;
   localparam int unsigned FLBITS   = 4;
   localparam int unsigned FL_VALID = 0;
   localparam int unsigned FL_DIRTY = 1;
   localparam int unsigned LINE_W   = 8 * (1 << LNBITS);
   localparam int unsigned CNT_W    = IBITS + WAYBITS;

   typedef enum logic [2:0] {
      IDLE,
      RD,
      CHK,
      WB,
      INV,
      INV_W,
      DONE
   } state_t;

   typedef logic [CNT_W-1:0] cnt_t;

   typedef struct packed {
      logic [ABUS-1:0]   addr;
      logic [LINE_W-1:0] data;
   } wb_req_t;

   // Direct-access address: way in the low bits, line in the index field, rest zero.
   function automatic logic [ABUS-1:0] entry_addr(input cnt_t c);
      logic [ABUS-1:0] a;
      a = '0;
      a[WAYBITS-1:0] = c[WAYBITS-1:0];
      a[IBITS+LNBITS-1:LNBITS] = c[CNT_W-1:WAYBITS];
      return a;
   endfunction

endpackage

// File: rtl/tagmem_flush_if.sv
// Flush request, tag-memory direct-access and writeback signals of the flush sequencer.
// master = the sequencer, slave = cache controller / tag memory / bus side.
interface tagmem_flush_if;
   import tagmem_flush_pkg::*;

   logic                i_flush_valid;
   logic                i_flush_all;
   logic [ABUS-1:0]     i_flush_addr;
   logic                o_flush_ready;
   logic                o_flush_end;
   logic                o_busy;

   logic                o_direct_access;
   logic                o_invalidate;
   logic                o_re;
   logic [ABUS-1:0]     o_addr;
   logic [ABUS-1:0]     i_raddr;
   logic [LINE_W-1:0]   i_rdata;
   logic [FLBITS-1:0]   i_rflags;
   logic                i_hit;

   logic                o_wb_valid;
   logic [ABUS-1:0]     o_wb_addr;
   logic [LINE_W-1:0]   o_wb_data;
   logic                i_wb_ready;

   modport master (
      input  i_flush_valid, i_flush_all, i_flush_addr,
      input  i_raddr, i_rdata, i_rflags, i_hit, i_wb_ready,
      output o_flush_ready, o_flush_end, o_busy,
      output o_direct_access, o_invalidate, o_re, o_addr,
      output o_wb_valid, o_wb_addr, o_wb_data
   );

   modport slave (
      output i_flush_valid, i_flush_all, i_flush_addr,
      output i_raddr, i_rdata, i_rflags, i_hit, i_wb_ready,
      input  o_flush_ready, o_flush_end, o_busy,
      input  o_direct_access, o_invalidate, o_re, o_addr,
      input  o_wb_valid, o_wb_addr, o_wb_data
   );

endinterface

// File: rtl/tagmem_flush_ctrl.sv
// Flush/invalidate sequencer for an N-way tag memory: walks {line,way} entries, invalidates valid ones.
// Define TAGMEM_FLUSH_WRITEBACK_EN to write dirty lines back to the bus before invalidation.
module tagmem_flush_ctrl
   import tagmem_flush_pkg::*;
(
   input logic            i_clk,
   input logic            i_nrst,
   tagmem_flush_if.master bus
);

   state_t          state, state_n;
   cnt_t            cnt, cnt_n;
   cnt_t            last, last_n;
   logic            advance;
   logic            ready_n, busy_n, end_n, da_n, inv_n, re_n, wbv_n;
   logic [ABUS-1:0] addr_n;
   logic [IBITS-1:0] req_line;

`ifdef TAGMEM_FLUSH_WRITEBACK_EN
   wb_req_t wb_q, wb_n;
`endif

   assign req_line = bus.i_flush_addr[IBITS+LNBITS-1:LNBITS];

   // Next state, counter and next-cycle output values.
   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      last_n  = last;
      advance = 1'b0;
`ifdef TAGMEM_FLUSH_WRITEBACK_EN
      wb_n    = wb_q;
`endif

      case (state)
         IDLE: begin
            if (bus.i_flush_valid) begin
               if (bus.i_flush_all) begin
                  cnt_n  = '0;
                  last_n = '1;
               end else begin
                  cnt_n  = {req_line, WAYBITS'(0)};
                  last_n = {req_line, {WAYBITS{1'b1}}};
               end
               state_n = RD;
            end
         end
         RD:    state_n = CHK;
         CHK: begin
            if (!bus.i_rflags[FL_VALID]) begin
               advance = 1'b1;
`ifdef TAGMEM_FLUSH_WRITEBACK_EN
            end else if (bus.i_rflags[FL_DIRTY]) begin
               wb_n.addr = {bus.i_raddr[ABUS-1:LNBITS], LNBITS'(0)};
               wb_n.data = bus.i_rdata;
               state_n   = WB;
`endif
            end else begin
               state_n = INV;
            end
         end
         WB: begin
            if (bus.i_wb_ready) state_n = INV;
         end
         INV:   state_n = INV_W;
         INV_W: advance = 1'b1;
         DONE:  state_n = IDLE;
         default: state_n = IDLE;
      endcase

      // Terminal count ends the walk; all-mode stops before the counter wraps.
      if (advance) begin
         if (cnt == last) begin
            state_n = DONE;
         end else begin
            cnt_n   = cnt + cnt_t'(1);
            state_n = RD;
         end
      end

      ready_n = (state_n == IDLE);
      busy_n  = state_n inside {RD, CHK, WB, INV, INV_W};
      da_n    = state_n inside {RD, INV, INV_W};
      re_n    = (state_n == RD);
      inv_n   = (state_n == INV);
      end_n   = (state_n == DONE);
      wbv_n   = (state_n == WB);
      addr_n  = busy_n ? entry_addr(cnt_n) : '0;
   end

   // State, counter and registered control outputs.
   always_ff @(posedge i_clk) begin
      if (!i_nrst) begin
         state               <= IDLE;
         cnt                 <= '0;
         last                <= '0;
         bus.o_flush_ready   <= 1'b1;
         bus.o_flush_end     <= 1'b0;
         bus.o_busy          <= 1'b0;
         bus.o_direct_access <= 1'b0;
         bus.o_invalidate    <= 1'b0;
         bus.o_re            <= 1'b0;
         bus.o_addr          <= '0;
      end else begin
         state               <= state_n;
         cnt                 <= cnt_n;
         last                <= last_n;
         bus.o_flush_ready   <= ready_n;
         bus.o_flush_end     <= end_n;
         bus.o_busy          <= busy_n;
         bus.o_direct_access <= da_n;
         bus.o_invalidate    <= inv_n;
         bus.o_re            <= re_n;
         bus.o_addr          <= addr_n;
      end
   end

`ifdef TAGMEM_FLUSH_WRITEBACK_EN
   // Writeback request held stable from the latch in CHK until accepted.
   always_ff @(posedge i_clk) begin
      if (!i_nrst) begin
         wb_q           <= '0;
         bus.o_wb_valid <= 1'b0;
      end else begin
         wb_q           <= wb_n;
         bus.o_wb_valid <= wbv_n;
      end
   end

   assign bus.o_wb_addr = wb_q.addr;
   assign bus.o_wb_data = wb_q.data;
`else
   assign bus.o_wb_valid = 1'b0;
   assign bus.o_wb_addr  = '0;
   assign bus.o_wb_data  = '0;
`endif

   // Inputs only partially consumed (hit, address low bits, spare flags).
   logic unused_inputs;
   assign unused_inputs = ^{bus.i_hit, bus.i_raddr, bus.i_rdata, bus.i_rflags,
                            bus.i_flush_addr, bus.i_wb_ready, wbv_n};

endmodule

// File: tb/tb_tagmem_flush_ctrl.sv
// Directed self-checking bench for tagmem_flush_ctrl with a small tag-memory model.
module tb_tagmem_flush_ctrl;
   import tagmem_flush_pkg::*;

   logic clk  = 1'b0;
   logic nrst = 1'b0;
   int   checks = 0;
   int   errors = 0;

   tagmem_flush_if bus ();

   tagmem_flush_ctrl u_dut (
      .i_clk  (clk),
      .i_nrst (nrst),
      .bus    (bus)
   );

   always #5 clk = ~clk;

   // Tag-memory model: one-cycle read latency, invalidation tracked per epoch.
   logic [FLBITS-1:0] flags_m   [256];
   logic [ABUS-1:0]   raddr_m   [256];
   logic [FLBITS-1:0] rflag_seen[256];
   int                clr_epoch [256] = '{default: -1};
   int                epoch = 0;
   int                mi;

   function automatic int idx_of(input logic [ABUS-1:0] a);
      return int'({a[IBITS+LNBITS-1:LNBITS], a[WAYBITS-1:0]});
   endfunction

   always @(posedge clk) begin : model
      mi = idx_of(bus.o_addr);
      if (bus.o_re) begin
         if (flags_m[mi][FL_VALID] && clr_epoch[mi] != epoch) begin
            bus.i_rflags   <= flags_m[mi];
            bus.i_hit      <= 1'b1;
            rflag_seen[mi] <= flags_m[mi];
         end else begin
            bus.i_rflags   <= '0;
            bus.i_hit      <= 1'b0;
            rflag_seen[mi] <= '0;
         end
         bus.i_raddr <= raddr_m[mi];
         bus.i_rdata <= {4{raddr_m[mi]}};
      end
      if (bus.o_invalidate) clr_epoch[mi] <= epoch;
   end

   // Event monitor; edge numbers share one frame so differences give latencies.
   int cyc = 0, hs_edge = 0, hs_cnt = 0, end_edge = 0, end_cnt = 0;
   int inv_cnt = 0, re_cnt = 0, wb_cnt = 0, wb_unstable = 0, wb_last_edge = 0;
   int rd_edge [256] = '{default: -1};
   int inv_edge[256] = '{default: -1};
   logic [ABUS-1:0]   last_re_addr = '0, last_inv_addr = '0, prev_wb_addr = '0;
   logic [LINE_W-1:0] prev_wb_data = '0;
   logic              prev_wb_valid = 1'b0;

   always @(posedge clk) begin : monitor
      cyc <= cyc + 1;
      if (bus.i_flush_valid && bus.o_flush_ready) begin
         hs_edge <= cyc;
         hs_cnt  <= hs_cnt + 1;
      end
      if (bus.o_flush_end) begin
         end_edge <= cyc;
         end_cnt  <= end_cnt + 1;
      end
      if (bus.o_re) begin
         re_cnt                    <= re_cnt + 1;
         rd_edge[idx_of(bus.o_addr)] <= cyc;
         last_re_addr              <= bus.o_addr;
      end
      if (bus.o_invalidate) begin
         inv_cnt                    <= inv_cnt + 1;
         inv_edge[idx_of(bus.o_addr)] <= cyc;
         last_inv_addr              <= bus.o_addr;
      end
      if (bus.o_wb_valid) begin
         wb_cnt       <= wb_cnt + 1;
         wb_last_edge <= cyc;
         if (prev_wb_valid && (bus.o_wb_addr != prev_wb_addr || bus.o_wb_data != prev_wb_data))
            wb_unstable <= wb_unstable + 1;
      end
      prev_wb_valid <= bus.o_wb_valid;
      prev_wb_addr  <= bus.o_wb_addr;
      prev_wb_data  <= bus.o_wb_data;
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic clear_mem();
      epoch++;
      for (int i = 0; i < 256; i++) begin
         flags_m[i] = '0;
         raddr_m[i] = 64'h1000_0000 + 64'(i * 32);
      end
   endtask

   task automatic start(input logic all, input logic [ABUS-1:0] a);
      int n = 0;
      while (!bus.o_flush_ready && n < 40) begin
         step(1);
         n++;
      end
      bus.i_flush_valid = 1'b1;
      bus.i_flush_all   = all;
      bus.i_flush_addr  = a;
      step(1);
      bus.i_flush_valid = 1'b0;
   endtask

   task automatic wait_end(input int max_cyc, input string tag);
      int n = 0;
      while (!bus.o_flush_end && n < max_cyc) begin
         step(1);
         n++;
      end
      check(tag, 64'(bus.o_flush_end), 64'd1);
      step(1);
   endtask

   int base_inv, base_wb, base_re, base_end, base_hs;

   initial begin
      bus.i_flush_valid = 1'b0;
      bus.i_flush_all   = 1'b0;
      bus.i_flush_addr  = '0;
      bus.i_wb_ready    = 1'b0;
      clear_mem();

      // Reset state
      step(3);
      check("rst_ready", 64'(bus.o_flush_ready), 64'd1);
      check("rst_busy",  64'(bus.o_busy), 64'd0);
      check("rst_end",   64'(bus.o_flush_end), 64'd0);
      check("rst_re",    64'(bus.o_re), 64'd0);
      check("rst_addr",  bus.o_addr, 64'd0);
      check("rst_wbv",   64'(bus.o_wb_valid), 64'd0);
      nrst = 1'b1;
      step(1);
      check("idle_ready", 64'(bus.o_flush_ready), 64'd1);

      // Empty cache, whole-cache flush: 256 entries x 2 cycles
      base_inv = inv_cnt; base_wb = wb_cnt; base_re = re_cnt;
      start(1'b1, '0);
      check("all_busy",  64'(bus.o_busy), 64'd1);
      check("all_re",    64'(bus.o_re), 64'd1);
      check("all_da",    64'(bus.o_direct_access), 64'd1);
      check("all_addr0", bus.o_addr, 64'd0);
      check("all_ready", 64'(bus.o_flush_ready), 64'd0);
      wait_end(700, "all_end_seen");
      check("all_latency", 64'(end_edge - hs_edge), 64'd513);
      check("all_no_inv",  64'(inv_cnt - base_inv), 64'd0);
      check("all_no_wb",   64'(wb_cnt - base_wb), 64'd0);
      check("all_reads",   64'(re_cnt - base_re), 64'd256);

      // Line mode, empty line 0x12
      base_re = re_cnt; base_inv = inv_cnt;
      start(1'b0, 64'h1240);
      check("line_addr_first", bus.o_addr, 64'h240);
      wait_end(40, "line_end_seen");
      check("line_latency",   64'(end_edge - hs_edge), 64'd9);
      check("line_reads",     64'(re_cnt - base_re), 64'd4);
      check("line_addr_last", last_re_addr, 64'h243);
      check("line_no_inv",    64'(inv_cnt - base_inv), 64'd0);

      // Line 0x12 with ways 1 and 3 valid/clean
      clear_mem();
      flags_m[73] = 4'b0001;
      flags_m[75] = 4'b0001;
      base_inv = inv_cnt;
      start(1'b0, 64'h1240);
      wait_end(40, "line2_end_seen");
      check("line2_latency", 64'(end_edge - hs_edge), 64'd13);
      check("line2_inv_cnt", 64'(inv_cnt - base_inv), 64'd2);
      check("line2_w1_inv",  64'(inv_edge[73] > hs_edge), 64'd1);
      check("line2_w3_inv",  64'(inv_edge[75] > hs_edge), 64'd1);
      check("line2_w0_keep", 64'(inv_edge[72] == -1), 64'd1);
      check("line2_w2_keep", 64'(inv_edge[74] == -1), 64'd1);

      // Line 3 way 2 valid/clean, then re-read
      clear_mem();
      flags_m[14] = 4'b0001;
      start(1'b0, 64'h60);
      wait_end(40, "clean_end_seen");
      check("clean_inv_gap",  64'(inv_edge[14] - rd_edge[14]), 64'd2);
      check("clean_inv_addr", last_inv_addr, 64'h62);
      check("clean_latency",  64'(end_edge - hs_edge), 64'd11);
      base_inv = inv_cnt;
      start(1'b0, 64'h60);
      wait_end(40, "reread_end_seen");
      check("reread_flags",   64'(rflag_seen[14]), 64'd0);
      check("reread_no_inv",  64'(inv_cnt - base_inv), 64'd0);
      check("reread_latency", 64'(end_edge - hs_edge), 64'd9);

      // Dirty entry at line 5 way 1, unaligned read address
      clear_mem();
      flags_m[21] = 4'b0011;
      raddr_m[21] = 64'h8000_005A;
      bus.i_wb_ready = 1'b0;
      base_wb = wb_cnt;
      start(1'b0, 64'hA0);
`ifdef TAGMEM_FLUSH_WRITEBACK_EN
      begin
         int n = 0;
         while (!bus.o_wb_valid && n < 20) begin
            step(1);
            n++;
         end
      end
      check("wb_valid",     64'(bus.o_wb_valid), 64'd1);
      check("wb_addr",      bus.o_wb_addr, 64'h8000_0040);
      check("wb_data",      64'(bus.o_wb_data === {4{64'h8000_005A}}), 64'd1);
      step(5);
      check("wb_held",      64'(bus.o_wb_valid), 64'd1);
      bus.i_wb_ready = 1'b1;
      step(1);
      bus.i_wb_ready = 1'b0;
      check("wb_then_inv",  64'(bus.o_invalidate), 64'd1);
      check("wb_inv_addr",  bus.o_addr, 64'hA1);
      wait_end(40, "wb_end_seen");
      check("wb_cycles",    64'(wb_cnt - base_wb), 64'd6);
      check("wb_stable",    64'(wb_unstable), 64'd0);
      check("wb_inv_edge",  64'(inv_edge[21] - wb_last_edge), 64'd1);
      check("wb_latency",   64'(end_edge - hs_edge), 64'd17);
`else
      wait_end(40, "nowb_end_seen");
      check("nowb_cycles",  64'(wb_cnt - base_wb), 64'd0);
      check("nowb_inv_gap", 64'(inv_edge[21] - rd_edge[21]), 64'd2);
      check("nowb_latency", 64'(end_edge - hs_edge), 64'd11);
      check("nowb_wbaddr",  bus.o_wb_addr, 64'd0);
`endif

      // Reset in the middle of a flush
      clear_mem();
      flags_m[21] = 4'b0011;
      raddr_m[21] = 64'h8000_005A;
      base_inv = inv_cnt;
      base_end = end_cnt;
      start(1'b0, 64'hA0);
`ifdef TAGMEM_FLUSH_WRITEBACK_EN
      begin
         int n = 0;
         while (!bus.o_wb_valid && n < 20) begin
            step(1);
            n++;
         end
      end
      check("abort_in_wb", 64'(bus.o_wb_valid), 64'd1);
      step(2);
`else
      step(3);
`endif
      nrst = 1'b0;
      step(1);
      check("abort_ready",   64'(bus.o_flush_ready), 64'd1);
      check("abort_busy",    64'(bus.o_busy), 64'd0);
      check("abort_end",     64'(bus.o_flush_end), 64'd0);
      check("abort_re",      64'(bus.o_re), 64'd0);
      check("abort_inv",     64'(bus.o_invalidate), 64'd0);
      check("abort_da",      64'(bus.o_direct_access), 64'd0);
      check("abort_addr",    bus.o_addr, 64'd0);
      check("abort_wbv",     64'(bus.o_wb_valid), 64'd0);
      check("abort_wbaddr",  bus.o_wb_addr, 64'd0);
      nrst = 1'b1;
      step(3);
      check("abort_no_end",  64'(end_cnt - base_end), 64'd0);
      check("abort_no_clr",  64'(inv_cnt - base_inv), 64'd0);
      bus.i_wb_ready = 1'b1;
      start(1'b1, '0);
      check("restart_addr0", bus.o_addr, 64'd0);
      check("restart_re",    64'(bus.o_re), 64'd1);
      wait_end(700, "restart_end_seen");
`ifdef TAGMEM_FLUSH_WRITEBACK_EN
      check("restart_latency", 64'(end_edge - hs_edge), 64'd516);
`else
      check("restart_latency", 64'(end_edge - hs_edge), 64'd515);
`endif
      check("restart_inv_cnt", 64'(inv_cnt - base_inv), 64'd1);
      bus.i_wb_ready = 1'b0;

      // Second request while busy waits for IDLE
      clear_mem();
      start(1'b0, 64'h400);
      bus.i_flush_valid = 1'b1;
      bus.i_flush_all   = 1'b0;
      bus.i_flush_addr  = 64'h420;
      base_hs = hs_cnt;
      begin
         int n = 0;
         while (!bus.o_flush_end && n < 40) begin
            step(1);
            n++;
         end
      end
      check("busy_done_seen",  64'(bus.o_flush_end), 64'd1);
      check("busy_done_ready", 64'(bus.o_flush_ready), 64'd0);
      check("busy_ignored",    64'(hs_cnt - base_hs), 64'd0);
      step(1);
      check("idle_ready2",     64'(bus.o_flush_ready), 64'd1);
      check("idle_not_yet",    64'(hs_cnt - base_hs), 64'd0);
      step(1);
      check("second_accept",   64'(hs_cnt - base_hs), 64'd1);
      check("second_hs_edge",  64'(hs_edge - end_edge), 64'd1);
      check("second_busy",     64'(bus.o_busy), 64'd1);
      check("second_addr",     bus.o_addr, 64'h420);
      bus.i_flush_valid = 1'b0;
      wait_end(40, "second_end_seen");
      check("second_latency",  64'(end_edge - hs_edge), 64'd9);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
